// File: rtl/param_loader_generic.sv
// param_loader_generic: fetches a runtime-selected number of W-bit words from a
// BRAM, starting at a runtime base address, and packs them into a flat register.
// One read address is issued per cycle. An RD_LAT-deep tag pipe marks which
// cycles carry returning read data, so the design tolerates any BRAM latency >= 1.
//
// Handshake: a load request is accepted only when the FSM is in IDLE and `start`
// is high on a rising edge. `busy` covers the issue and drain phases. `done` is a
// one-cycle pulse in the DONE state. `valid` rises together with `done` and stays
// high until the next accepted request.
module param_loader_generic #(
    parameter int W          = 8,
    parameter int MAX_WORDS  = 8,
    parameter int ADDR_WIDTH = 18,
    parameter int RD_LAT     = 2,
    parameter int CNT_W      = $clog2(MAX_WORDS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [CNT_W-1:0]        word_count,
    output logic                    bram_en,
    output logic [ADDR_WIDTH-1:0]   bram_addr,
    input  logic [W-1:0]            bram_dout,
    output logic [MAX_WORDS*W-1:0]  data_out,
    output logic                    busy,
    output logic                    done,
    output logic                    valid,
    output logic [1:0]              dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]      MAX_N  = CNT_W'(MAX_WORDS);
    localparam logic [CNT_W-1:0]      ONE_C  = CNT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE_A  = ADDR_WIDTH'(1);

    state_t                   state_q, state_d;
    logic                     en_q, en_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [CNT_W-1:0]         n_q, n_d;
    logic [CNT_W-1:0]         issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [MAX_WORDS*W-1:0]   data_q, data_d;
    logic                     valid_q, valid_d;
    logic [RD_LAT-1:0]        tag_q, tag_d;
    logic [CNT_W-1:0]         n_req;

    // Requests larger than the output capacity are clamped to MAX_WORDS.
    assign n_req = (word_count > MAX_N) ? MAX_N : word_count;

    // Next-state, address issue, tag pipe and return capture.
    always_comb begin
        state_d     = state_q;
        en_d        = 1'b0;
        addr_d      = addr_q;
        n_d         = n_q;
        issue_cnt_d = issue_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        data_d      = data_q;
        valid_d     = valid_q;

        // Tag enters the pipe in the cycle the read is presented; it emerges
        // from the top bit in the cycle the BRAM data is on bram_dout.
        tag_d = tag_q;
        for (int i = RD_LAT - 1; i > 0; i--) begin
            tag_d[i] = tag_q[i-1];
        end
        tag_d[0] = en_q;

        if (tag_q[RD_LAT-1]) begin
            for (int s = 0; s < MAX_WORDS; s++) begin
                if (wr_ptr_q == CNT_W'(s)) begin
                    data_d[s*W +: W] = bram_dout;
                end
            end
            wr_ptr_d = wr_ptr_q + ONE_C;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d         = n_req;
                    data_d      = '0;
                    wr_ptr_d    = '0;
                    issue_cnt_d = '0;
                    if (n_req == '0) begin
                        state_d = S_DONE;
                        valid_d = 1'b1;
                    end else begin
                        state_d     = S_ISSUE;
                        valid_d     = 1'b0;
                        en_d        = 1'b1;
                        addr_d      = base_addr;
                        issue_cnt_d = ONE_C;
                    end
                end
            end
            S_ISSUE: begin
                if (issue_cnt_q < n_q) begin
                    en_d        = 1'b1;
                    addr_d      = addr_q + ONE_A;
                    issue_cnt_d = issue_cnt_q + ONE_C;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Use the post-capture pointer so DONE follows the last capture directly.
                if (wr_ptr_d == n_q) begin
                    state_d = S_DONE;
                    valid_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset; reset also flushes tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            en_q        <= 1'b0;
            addr_q      <= '0;
            n_q         <= '0;
            issue_cnt_q <= '0;
            wr_ptr_q    <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            tag_q       <= '0;
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            addr_q      <= addr_d;
            n_q         <= n_d;
            issue_cnt_q <= issue_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            tag_q       <= tag_d;
        end
    end

    assign bram_en     = en_q;
    assign bram_addr   = addr_q;
    assign data_out    = data_q;
    assign valid       = valid_q;
    assign busy        = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done        = (state_q == S_DONE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_param_loader_generic.sv
// Directed bench for param_loader_generic: three instances (RD_LAT = 2, 1, 3),
// each fed by a BRAM model with mem[a] = a[7:0] and a matching read latency.
module tb_param_loader_generic;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start_v;
    logic [17:0] base_addr;
    logic [3:0]  word_count;

    logic        en_v    [3];
    logic [17:0] addr_v  [3];
    logic [7:0]  dout_v  [3];
    logic [63:0] data_v  [3];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic        valid_v [3];
    logic [1:0]  st_v    [3];

    int n_vec  = 0;
    int n_fail = 0;
    logic [17:0] got_addr[$];

    always #5 clk = ~clk;

    param_loader_generic #(.RD_LAT(2)) u_lat2 (
        .clk(clk), .rst(rst), .start(start_v[0]), .base_addr(base_addr),
        .word_count(word_count), .bram_en(en_v[0]), .bram_addr(addr_v[0]),
        .bram_dout(dout_v[0]), .data_out(data_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .valid(valid_v[0]), .dbg_state_o(st_v[0])
    );

    param_loader_generic #(.RD_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .base_addr(base_addr),
        .word_count(word_count), .bram_en(en_v[1]), .bram_addr(addr_v[1]),
        .bram_dout(dout_v[1]), .data_out(data_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .valid(valid_v[1]), .dbg_state_o(st_v[1])
    );

    param_loader_generic #(.RD_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .start(start_v[2]), .base_addr(base_addr),
        .word_count(word_count), .bram_en(en_v[2]), .bram_addr(addr_v[2]),
        .bram_dout(dout_v[2]), .data_out(data_v[2]), .busy(busy_v[2]),
        .done(done_v[2]), .valid(valid_v[2]), .dbg_state_o(st_v[2])
    );

    // BRAM models: data for the address presented in cycle c is on dout in c+RD_LAT.
    logic [7:0] m2_p0, m2_p1, m1_p0, m3_p0, m3_p1, m3_p2;
    always @(posedge clk) begin
        m2_p0 <= addr_v[0][7:0];
        m2_p1 <= m2_p0;
        m1_p0 <= addr_v[1][7:0];
        m3_p0 <= addr_v[2][7:0];
        m3_p1 <= m3_p0;
        m3_p2 <= m3_p1;
    end
    assign dout_v[0] = m2_p1;
    assign dout_v[1] = m1_p0;
    assign dout_v[2] = m3_p2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one load on instance sel and observe cycles t0+1 .. done+1.
    // ign1/ign2 are cycle offsets at which an extra start pulse (base 0) is driven.
    task automatic run_load(input int sel, input logic [17:0] base, input logic [3:0] wc,
                            input int ign1, input int ign2,
                            output int done_k, output int en_cnt, output int busy_cnt,
                            output logic valid_k1, output logic valid_dn,
                            output logic [63:0] data_dn, output logic post_busy,
                            output logic post_done);
        done_k = 0; en_cnt = 0; busy_cnt = 0;
        valid_k1 = 1'bx; valid_dn = 1'b0; data_dn = 'x;
        post_busy = 1'bx; post_done = 1'bx;
        got_addr.delete();
        @(negedge clk);
        base_addr = base;
        word_count = wc;
        start_v[sel] = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start_v[sel] = (k == ign1) || (k == ign2);
            if (start_v[sel]) base_addr = 18'd0;
            if (k == 1) valid_k1 = valid_v[sel];
            if (done_k != 0) begin
                post_busy = busy_v[sel];
                post_done = done_v[sel];
                break;
            end
            if (en_v[sel]) begin
                en_cnt++;
                got_addr.push_back(addr_v[sel]);
            end
            if (busy_v[sel]) busy_cnt++;
            if (done_v[sel]) begin
                done_k = k;
                valid_dn = valid_v[sel];
                data_dn = data_v[sel];
            end
        end
        start_v[sel] = 1'b0;
    endtask

    int          dk, ec, bc;
    logic        vk1, vdn, pb, pd, late;
    logic [63:0] dd;
    logic [17:0] exp_wrap[5];

    initial begin
        rst = 1'b1;
        start_v = 3'b000;
        base_addr = '0;
        word_count = '0;
        exp_wrap[0] = 18'd262141; exp_wrap[1] = 18'd262142; exp_wrap[2] = 18'd262143;
        exp_wrap[3] = 18'd0;      exp_wrap[4] = 18'd1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_en",    64'(en_v[0]),    64'd0);
        chk("rst_addr",  64'(addr_v[0]),  64'd0);
        chk("rst_data",  data_v[0],       64'd0);
        chk("rst_busy",  64'(busy_v[0]),  64'd0);
        chk("rst_done",  64'(done_v[0]),  64'd0);
        chk("rst_valid", 64'(valid_v[0]), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Full load, with start pulses during ISSUE (t0+3) and DONE (t0+11)
        run_load(0, 18'd147472, 4'd8, 3, 11, dk, ec, bc, vk1, vdn, dd, pb, pd);
        chk("full_done_k", 64'(dk), 64'd11);
        chk("full_en_cnt", 64'(ec), 64'd8);
        chk("full_busy",   64'(bc), 64'd10);
        chk("full_data",   dd, 64'h1716151413121110);
        chk("full_valid",  64'(vdn), 64'd1);
        chk("full_addr0",  64'(got_addr[0]), 64'd147472);
        chk("full_addr7",  64'(got_addr[7]), 64'd147479);
        chk("ign_busy",    64'(pb), 64'd0);
        chk("done_pulse",  64'(pd), 64'd0);
        repeat (3) @(negedge clk);
        chk("valid_hold",  64'(valid_v[0]), 64'd1);
        chk("data_hold",   data_v[0], 64'h1716151413121110);

        // Address wrap
        run_load(0, 18'd262141, 4'd5, 0, 0, dk, ec, bc, vk1, vdn, dd, pb, pd);
        chk("wrap_done_k", 64'(dk), 64'd8);
        chk("wrap_en_cnt", 64'(ec), 64'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < got_addr.size()) chk($sformatf("wrap_addr%0d", i), 64'(got_addr[i]), 64'(exp_wrap[i]));
            else chk($sformatf("wrap_addr%0d", i), 64'hdead, 64'(exp_wrap[i]));
        end
        chk("wrap_data", dd, 64'h0000000100fffefd);

        // Partial load n=3
        run_load(0, 18'd147472, 4'd3, 0, 0, dk, ec, bc, vk1, vdn, dd, pb, pd);
        chk("n3_done_k", 64'(dk), 64'd6);
        chk("n3_data",   dd, 64'h0000000000121110);
        chk("n3_busy",   64'(bc), 64'd5);

        // Empty load n=0
        run_load(0, 18'd147472, 4'd0, 0, 0, dk, ec, bc, vk1, vdn, dd, pb, pd);
        chk("n0_done_k", 64'(dk), 64'd1);
        chk("n0_en_cnt", 64'(ec), 64'd0);
        chk("n0_busy",   64'(bc), 64'd0);
        chk("n0_data",   dd, 64'd0);
        chk("n0_valid",  64'(vdn), 64'd1);

        // Clamp word_count=12 to 8
        run_load(0, 18'd147472, 4'd12, 0, 0, dk, ec, bc, vk1, vdn, dd, pb, pd);
        chk("clamp_done_k", 64'(dk), 64'd11);
        chk("clamp_en_cnt", 64'(ec), 64'd8);
        chk("clamp_data",   dd, 64'h1716151413121110);

        // Second load replaces the first; valid drops at t0+1
        run_load(0, 18'd0, 4'd4, 0, 0, dk, ec, bc, vk1, vdn, dd, pb, pd);
        chk("reload_valid_k1", 64'(vk1), 64'd0);
        chk("reload_done_k",   64'(dk), 64'd7);
        chk("reload_data",     dd, 64'h0000000003020100);

        // Reset after three addresses have been issued
        @(negedge clk);
        base_addr = 18'd147472;
        word_count = 4'd8;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_en",    64'(en_v[0]),    64'd0);
        chk("mrst_addr",  64'(addr_v[0]),  64'd0);
        chk("mrst_data",  data_v[0],       64'd0);
        chk("mrst_busy",  64'(busy_v[0]),  64'd0);
        chk("mrst_done",  64'(done_v[0]),  64'd0);
        chk("mrst_valid", 64'(valid_v[0]), 64'd0);
        late = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (en_v[0] || (data_v[0] != 64'd0) || valid_v[0] || done_v[0]) late = 1'b1;
        end
        chk("mrst_late", 64'(late), 64'd0);
        run_load(0, 18'd32, 4'd4, 0, 0, dk, ec, bc, vk1, vdn, dd, pb, pd);
        chk("fresh_done_k", 64'(dk), 64'd7);
        chk("fresh_data",   dd, 64'h0000000023222120);

        // rst and start together: stays idle
        @(negedge clk);
        rst = 1'b1;
        start_v[0] = 1'b1;
        base_addr = 18'd147472;
        word_count = 4'd8;
        @(negedge clk);
        rst = 1'b0;
        start_v[0] = 1'b0;
        chk("rs_busy0", 64'(busy_v[0]), 64'd0);
        chk("rs_en0",   64'(en_v[0]),   64'd0);
        @(negedge clk);
        chk("rs_busy1", 64'(busy_v[0]), 64'd0);
        chk("rs_en1",   64'(en_v[0]),   64'd0);
        chk("rs_valid", 64'(valid_v[0]), 64'd0);

        // Latency sweep
        run_load(1, 18'd147472, 4'd8, 0, 0, dk, ec, bc, vk1, vdn, dd, pb, pd);
        chk("lat1_done_k", 64'(dk), 64'd10);
        chk("lat1_data",   dd, 64'h1716151413121110);
        chk("lat1_busy",   64'(bc), 64'd9);
        run_load(2, 18'd147472, 4'd8, 0, 0, dk, ec, bc, vk1, vdn, dd, pb, pd);
        chk("lat3_done_k", 64'(dk), 64'd12);
        chk("lat3_data",   dd, 64'h1716151413121110);
        chk("lat3_busy",   64'(bc), 64'd11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/param_loader_generic.md
# param_loader_generic

Parametrised successor to the fixed-address bias loaders. On a `start` pulse it fetches a runtime-selected number of W-bit words from a runtime-selected BRAM base address and packs them into a flat output register. It tolerates a configurable BRAM read latency and signals completion with a `done` pulse and a `valid` level. It drives a shared external BRAM read port, so one instance can load weights or biases for any layer.

## Interface
- `W`, 8: word width in bits.
- `MAX_WORDS`, 8: capacity of `data_out` in words.
- `ADDR_WIDTH`, 18: BRAM address width.
- `RD_LAT`, 2: BRAM read latency in cycles, ≥1.
- `CNT_W`, $clog2(MAX_WORDS+1): width of `word_count`.

- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: load request; sampled only in IDLE.
- `base_addr` in ADDR_WIDTH: first BRAM address; latched on an accepted `start`.
- `word_count` in CNT_W: number of words to load; latched on an accepted `start`.
- `bram_en` out 1: BRAM read enable; registered.
- `bram_addr` out ADDR_WIDTH: BRAM read address; registered.
- `bram_dout` in W: BRAM read data.
- `data_out` out MAX_WORDS*W: packed result; word i is at bits [i*W +: W].
- `busy` out 1: high from the cycle after an accepted `start` until the done cycle, exclusive.
- `done` out 1: one-cycle completion pulse.
- `valid` out 1: `data_out` holds a complete load; stays high until the next accepted `start`.

## Operation
- The state machine has four states: IDLE, ISSUE, DRAIN, DONE.
- IDLE + `start`:
  - Latch `base_addr`.
  - Latch n = min(`word_count`, MAX_WORDS); counts above MAX_WORDS are clamped.
  - Clear `data_out` to 0 and drop `valid`.
  - If n=0, go to DONE. Otherwise go to ISSUE.
- ISSUE:
  - Drive `bram_en`=1 and `bram_addr`=base+i for i=0..n-1, one address per cycle.
  - Address arithmetic is modulo 2^ADDR_WIDTH, so the sequence wraps past the top address to 0.
  - After address n-1 is issued, go to DRAIN with `bram_en`=0.
- Return tracking: an RD_LAT-deep valid-tag shift register tracks each issued read. When a tag emerges, write `bram_dout` into slot `write_ptr` and increment `write_ptr`.
- DRAIN: wait until `write_ptr`==n, then go to DONE.
- DONE: lasts exactly one cycle. Assert `done`=1, set `valid`=1, then return to IDLE.
- Slots n..MAX_WORDS-1 remain 0.
- `start` is ignored in ISSUE, DRAIN and DONE. A new request is accepted from IDLE in the cycle after DONE at the earliest.
- `rst` has priority over `start`. Mid-operation reset:
  - Returns the block to IDLE.
  - Clears all outputs.
  - Discards in-flight tags, so late BRAM data is never written.

## Timing
- Reset values: `bram_en`=0, `bram_addr`=0, `data_out`=0, `busy`=0, `done`=0, `valid`=0; internal pointers and tags are 0.
- Let `start` be accepted in cycle t0. Then:
  - `bram_addr`=base+i in cycle t0+1+i.
  - Word i is on `bram_dout` in cycle t0+1+i+RD_LAT and is captured at the end of that cycle.
  - `done`=1 in cycle t0+n+RD_LAT+1.
- `valid` and the final `data_out` are visible in the same cycle as `done`.
- n=0: `done` is asserted in cycle t0+1 with no BRAM access.
- `bram_en` is high for exactly n consecutive cycles per load.
- `busy` is high in cycles t0+1 through t0+n+RD_LAT inclusive. For n=0, `busy` is never high.
- Throughput: one word per cycle, with no bubbles between issued addresses.

## Test plan
- Full load with RD_LAT=2 and a BRAM model where mem[a]=a[7:0]; `start` with base=147472, n=8:
  - Slot i = 0x10+i.
  - `done` pulses exactly at t0+11.
  - `bram_en` is high for 8 cycles.
  - `valid` stays high afterwards.
- Address wrap: base=262141, n=5 → addresses 262141, 262142, 262143, 0, 1 appear in order, and slots 0..4 carry the matching data.
- Partial and edge counts:
  - n=3 → slots 3..7 are 0 and `done` is at t0+6.
  - n=0 → `done` is at t0+1, `data_out`=0, `valid`=1, and BRAM is never enabled.
  - `word_count`=12 → clamped to 8 words.
- Handshake:
  - `start` pulsed during ISSUE and during DONE → ignored; the load completes unchanged.
  - A second load with base=0, n=4 after completion → `valid` drops at t0+1 and `data_out` holds only the new data.
- Reset mid-load: `rst` after 3 addresses are issued →
  - The next cycle shows all outputs 0.
  - No later writes occur.
  - A fresh `start` then completes correctly.
  - `rst` and `start` in the same cycle → stays in IDLE.
- Latency sweep: RD_LAT=1 and RD_LAT=3 with n=8 → `done` at t0+10 and t0+12 respectively, with correct data in every slot.
